seq_multiplier: RTL

- Iterative shift-add unsigned multiplier; the inverse-operation companion of the team's sequential divider.
- Processes one multiplier bit per clock through a single WIDTH-bit adder with carry-out.
- Uses the same Run/Ready start-done protocol as the divider, so the CPU datapath can treat both blocks interchangeably.

---
 rtl/mult_pkg.sv | 27 ++
 rtl/seq_multiplier_if.sv | 37 +++
 rtl/mult_adder.sv | 21 ++
 rtl/seq_multiplier.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared types and constants for the iterative shift-add multiplier.
//   state_t        : FSM encoding {IDLE, CALC, DONE, FIX}
//   DEFAULT_WIDTH  : default operand width (Product is twice this)
//   cnt_width()    : iteration-counter width for a given operand width
//   CNT_W          : counter width for the default operand width
// ----------------------------------------------------------------------------
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Counter must hold 0..w-1; keep at least one bit for degenerate widths.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_multiplier_if.sv
// ----------------------------------------------------------------------------
// seq_multiplier_if
// Run/Ready start-done bundle shared with the sequential divider.
//   Multiplicand : operand A, sampled on the Run-accept edge
//   Multiplier   : operand B, sampled on the Run-accept edge
//   Run          : start request (level-sampled)
//   Product      : 2*WIDTH-bit result register {hi,lo}
//   Ready        : Product valid and block idle
// Modports: master (requester, e.g. CPU datapath), slave (multiplier).
// ----------------------------------------------------------------------------
interface seq_multiplier_if #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);

    logic [WIDTH-1:0]   Multiplicand;
    logic [WIDTH-1:0]   Multiplier;
    logic               Run;
    logic [2*WIDTH-1:0] Product;
    logic               Ready;

    modport master (
        output Multiplicand,
        output Multiplier,
        output Run,
        input  Product,
        input  Ready
    );

    modport slave (
        input  Multiplicand,
        input  Multiplier,
        input  Run,
        output Product,
        output Ready
    );

endinterface

// File: rtl/mult_adder.sv
// ----------------------------------------------------------------------------
// mult_adder
// Purely combinational WIDTH-bit adder with carry-out; the arithmetic half of
// the multiplier, split out the same way as the divider's ALU.
//   a, b  : WIDTH-bit addends
//   sum   : WIDTH-bit sum
//   carry : carry-out of the MSB
// ----------------------------------------------------------------------------
module mult_adder #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Zero-extend both addends so the carry falls out as the top result bit.
    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier: one multiplier bit per clock through a
// single WIDTH-bit adder. Product register doubles as the multiplier shift
// register: the low half starts as B and is consumed from bit 0 while the
// partial sum grows into the high half.
//
// Ports:
//   clk   : rising-edge clock
//   Reset : synchronous, active-high reset (highest priority)
//   bus   : seq_multiplier_if.slave (Multiplicand, Multiplier, Run in;
//           Product, Ready out)
//
// Latency: Run accepted at edge E0, Ready/Product final after WIDTH further
// edges (WIDTH+1 edges counting E0).
//
// Optional feature (macro MULT_SIGNED_EN): two's-complement operands. The
// magnitudes are multiplied and a FIX state negates the result when the
// operand signs differ, adding one edge of latency.
// ----------------------------------------------------------------------------
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 Reset,
    seq_multiplier_if.slave      bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] product;
    logic               ready;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;

    // Operand values captured on the accept edge.
    logic [WIDTH-1:0]   load_a;
    logic [WIDTH-1:0]   load_b;

`ifdef MULT_SIGNED_EN
    logic sign;
    logic load_sign;

    // NOTE: every signal driven from always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude 2^(WIDTH-1).
    always_comb begin
        load_a    = bus.Multiplicand[WIDTH-1] ? -bus.Multiplicand : bus.Multiplicand;
        load_b    = bus.Multiplier[WIDTH-1]   ? -bus.Multiplier   : bus.Multiplier;
        load_sign = bus.Multiplicand[WIDTH-1] ^ bus.Multiplier[WIDTH-1];
    end
`else
    assign load_a = bus.Multiplicand;
    assign load_b = bus.Multiplier;
`endif

    // Add the multiplicand only when the multiplier bit under inspection is 1.
    assign addend = product[0] ? mcand : '0;

    mult_adder #(.WIDTH(WIDTH)) u_adder (
        .a     (product[2*WIDTH-1:WIDTH]),
        .b     (addend),
        .sum   (sum),
        .carry (carry)
    );

    // NOTE: all state registers use non-blocking assignments so every branch
    // reads the pre-edge values of product/count, regardless of statement order.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state   <= IDLE;
            count   <= '0;
            mcand   <= '0;
            product <= '0;
            ready   <= 1'b0;
`ifdef MULT_SIGNED_EN
            sign    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.Run) begin
                        mcand   <= load_a;
                        product <= {{WIDTH{1'b0}}, load_b};
                        count   <= '0;
                        ready   <= 1'b0;
                        state   <= CALC;
`ifdef MULT_SIGNED_EN
                        sign    <= load_sign;
`endif
                    end
                end

                CALC: begin
                    // Carry-out lands in the MSB; dropping it corrupts
                    // products whose high half overflows WIDTH bits.
                    product <= {carry, sum, product[WIDTH-1:1]};
                    count   <= count + 1'b1;
                    if (count == LAST) begin
`ifdef MULT_SIGNED_EN
                        state <= FIX;
`else
                        state <= DONE;
                        ready <= 1'b1;
`endif
                    end
                end

                FIX: begin
`ifdef MULT_SIGNED_EN
                    if (sign) begin
                        product <= -product;
                    end
                    ready <= 1'b1;
                    state <= DONE;
`else
                    state <= IDLE;
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Product = product;
    assign bus.Ready   = ready;

endmodule
